// File: rtl/mgt_01_pkg.sv
// Shared types and defaults for the multiplier issue/retire scheduler.
package mgt_01_pkg;
  typedef logic [31:0] data_u;

  typedef enum logic [1:0] {
    MUL_U    = 2'd0,
    MULH_U   = 2'd1,
    MULHSU_U = 2'd2,
    MULHU_U  = 2'd3
  } mul_ops_e;

  localparam int MUL_LATENCY_DEF = 4;
  localparam int TAG_W_DEF       = 5;
endpackage

// File: rtl/mgt_01_mul_sched_if.sv
// Issue, multiplier and writeback signals of the scheduler; slave is the scheduler's view.
interface mgt_01_mul_sched_if
  import mgt_01_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int TAG_W       = TAG_W_DEF
);
  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  logic             issue_valid_i;
  logic             issue_ready_o;
  mul_ops_e         issue_ops_i;
  data_u            issue_op_A_i;
  data_u            issue_op_B_i;
  logic [TAG_W-1:0] issue_tag_i;
  logic             flush_i;
  data_u            mul_op_A_o;
  data_u            mul_op_B_o;
  mul_ops_e         mul_ops_o;
  logic             mul_clk_en_o;
  data_u            mul_result_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  data_u            wb_result_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic [CNT_W-1:0] inflight_o;
  logic             idle_o;

  modport slave (
    input  issue_valid_i, issue_ops_i, issue_op_A_i, issue_op_B_i, issue_tag_i,
           flush_i, mul_result_i, wb_ready_i,
    output issue_ready_o, mul_op_A_o, mul_op_B_o, mul_ops_o, mul_clk_en_o,
           wb_valid_o, wb_result_o, wb_tag_o, inflight_o, idle_o
  );

  modport master (
    output issue_valid_i, issue_ops_i, issue_op_A_i, issue_op_B_i, issue_tag_i,
           flush_i, mul_result_i, wb_ready_i,
    input  issue_ready_o, mul_op_A_o, mul_op_B_o, mul_ops_o, mul_clk_en_o,
           wb_valid_o, wb_result_o, wb_tag_o, inflight_o, idle_o
  );
endinterface

// File: rtl/mgt_01_mul_track.sv
// Valid/tag shift register that mirrors a fixed-latency, enable-gated datapath pipeline.
module mgt_01_mul_track
  import mgt_01_pkg::*;
#(
  parameter  int DEPTH = MUL_LATENCY_DEF,
  parameter  int TAG_W = TAG_W_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_vld,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [DEPTH-1:0]            vld,
  output logic [DEPTH-1:0][TAG_W-1:0] tag,
  output logic [CNT_W-1:0]            cnt
);
  logic [DEPTH-1:0]            vld_nxt;
  logic [DEPTH-1:0][TAG_W-1:0] tag_nxt;

  always_comb begin
    vld_nxt    = '0;
    tag_nxt    = '0;
    vld_nxt[0] = in_vld;
    tag_nxt[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i] = vld[i-1];
      tag_nxt[i] = tag[i-1];
    end
  end

  // Flush kills valids even while frozen; tags just follow the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
    end else begin
      if (flush)   vld <= '0;
      else if (en) vld <= vld_nxt;
      if (en)      tag <= tag_nxt;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(vld[i]);
  end
endmodule

// File: rtl/mgt_01_mul_sched.sv
// Issue/retire controller for the pipelined multiplier: gates its clock enable and tracks in-flight tags.
module mgt_01_mul_sched
  import mgt_01_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int TAG_W       = TAG_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  mgt_01_mul_sched_if.slave bus
);
  localparam int L     = MUL_LATENCY;
  localparam int CNT_W = $clog2(L + 1);

  logic [L-1:0]            vld_q;
  logic [L-1:0][TAG_W-1:0] tag_q;
  logic [CNT_W-1:0]        cnt;
  logic                    advance;
  logic                    accept;

  // A held result freezes the multiplier and tracker together; flush always frees them.
  assign advance = !(vld_q[L-1] && !bus.wb_ready_i) || bus.flush_i;
  assign accept  = bus.issue_valid_i && bus.issue_ready_o;

  assign bus.issue_ready_o = advance && !bus.flush_i;
  assign bus.mul_clk_en_o  = advance;
  assign bus.mul_op_A_o    = bus.issue_op_A_i;
  assign bus.mul_op_B_o    = bus.issue_op_B_i;
  assign bus.mul_ops_o     = bus.issue_ops_i;

  mgt_01_mul_track #(
    .DEPTH (L),
    .TAG_W (TAG_W)
  ) u_track (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (advance),
    .flush  (bus.flush_i),
    .in_vld (accept),
    .in_tag (bus.issue_tag_i),
    .vld    (vld_q),
    .tag    (tag_q),
    .cnt    (cnt)
  );

  assign bus.wb_valid_o  = vld_q[L-1] && !bus.flush_i;
  assign bus.wb_result_o = bus.mul_result_i;
  assign bus.wb_tag_o    = tag_q[L-1];
  assign bus.inflight_o  = cnt;
  assign bus.idle_o      = (cnt == '0);
endmodule

// File: tb/tb_mgt_01_mul_sched.sv
// Bench for mgt_01_mul_sched: queue scoreboard checked every cycle plus directed literal cases.
module tb_mgt_01_mul_sched;
  import mgt_01_pkg::*;

  localparam int L  = 4;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mgt_01_mul_sched_if #(.MUL_LATENCY(L), .TAG_W(TW)) bus ();

  mgt_01_mul_sched #(.MUL_LATENCY(L), .TAG_W(TW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic data_u ref_mul(input mul_ops_e op, input data_u a, input data_u b);
    logic signed [63:0] ss;
    logic signed [64:0] su;
    logic        [63:0] uu;
    data_u              lo;
    ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    su = $signed({{33{a[31]}}, a}) * $signed({33'b0, b});
    uu = {32'b0, a} * {32'b0, b};
    lo = a * b;
    case (op)
      MUL_U:    return lo;
      MULH_U:   return ss[63:32];
      MULHSU_U: return su[63:32];
      default:  return uu[63:32];
    endcase
  endfunction

  // Stand-in for the external multiplier: L enable-gated stages, the first capturing operands.
  data_u ip_pipe [L];
  always @(posedge clk) begin
    if (bus.mul_clk_en_o) begin
      ip_pipe[0] <= ref_mul(bus.mul_ops_o, bus.mul_op_A_o, bus.mul_op_B_o);
      for (int i = 1; i < L; i++) ip_pipe[i] <= ip_pipe[i-1];
    end
  end
  assign bus.mul_result_i = ip_pipe[L-1];

  // Scoreboard: accepted ops in issue order, each with the number of advancing edges it has seen.
  typedef struct {
    logic [TW-1:0] tag;
    data_u         res;
    int            adv;
  } op_t;

  op_t sb[$];
  bit  chk_on = 0;
  int  n_acc  = 0;
  int  n_ret  = 0;

  always @(negedge clk) begin
    bit  head;
    bit  adv_e;
    op_t e;
    if (chk_on) begin
      head  = (sb.size() > 0) && (sb[0].adv >= L - 1);
      adv_e = !(head && !bus.wb_ready_i) || bus.flush_i;
      chk("wb_valid", bus.wb_valid_o, head && !bus.flush_i);
      chk("clk_en", bus.mul_clk_en_o, adv_e);
      chk("issue_ready", bus.issue_ready_o, adv_e && !bus.flush_i);
      chk("inflight", bus.inflight_o, sb.size());
      chk("idle", bus.idle_o, sb.size() == 0);
      chk("op_a_pass", bus.mul_op_A_o, bus.issue_op_A_i);
      chk("op_b_pass", bus.mul_op_B_o, bus.issue_op_B_i);
      chk("ops_pass", bus.mul_ops_o, bus.issue_ops_i);
      if (head && !bus.flush_i) begin
        chk("wb_tag", bus.wb_tag_o, sb[0].tag);
        chk("wb_result", bus.wb_result_o, sb[0].res);
      end
      if (rst || bus.flush_i) begin
        sb.delete();
      end else if (adv_e) begin
        if (head && bus.wb_ready_i) begin
          void'(sb.pop_front());
          n_ret++;
        end
        for (int i = 0; i < sb.size(); i++) sb[i].adv = sb[i].adv + 1;
        if (bus.issue_valid_i) begin
          e.tag = bus.issue_tag_i;
          e.res = ref_mul(bus.issue_ops_i, bus.issue_op_A_i, bus.issue_op_B_i);
          e.adv = 0;
          sb.push_back(e);
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mul_ops_e op, input data_u a, input data_u b, input logic [TW-1:0] tag);
    bus.issue_valid_i = 1'b1;
    bus.issue_ops_i   = op;
    bus.issue_op_A_i  = a;
    bus.issue_op_B_i  = b;
    bus.issue_tag_i   = tag;
  endtask

  // Issue one op into an empty pipeline and pin latency, result and tag to literals.
  task automatic run_one(input string name, input mul_ops_e op, input data_u a, input data_u b,
                         input logic [TW-1:0] tag, input data_u exp);
    int c;
    drive(op, a, b, tag);
    tick();
    bus.issue_valid_i = 1'b0;
    @(negedge clk);
    chk({name, "_inflight1"}, bus.inflight_o, 1);
    c = 0;
    while (!bus.wb_valid_o && c < 8) begin
      tick();
      @(negedge clk);
      c++;
    end
    chk({name, "_latency"}, c, L - 1);
    chk({name, "_result"}, bus.wb_result_o, exp);
    chk({name, "_tag"}, bus.wb_tag_o, tag);
    tick();
    @(negedge clk);
    chk({name, "_inflight0"}, bus.inflight_o, 0);
    chk({name, "_idle"}, bus.idle_o, 1);
    tick();
  endtask

  data_u exp_stall [4] = '{32'd303, 32'd612, 32'd927, 32'd1248};

  initial begin
    int seen;
    int base_acc;
    int base_ret;
    int cyc;
    bus.issue_valid_i = 1'b0;
    bus.issue_ops_i   = MUL_U;
    bus.issue_op_A_i  = '0;
    bus.issue_op_B_i  = '0;
    bus.issue_tag_i   = '0;
    bus.flush_i       = 1'b0;
    bus.wb_ready_i    = 1'b1;
    @(posedge clk);
    chk_on = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_inflight", bus.inflight_o, 0);
    chk("rst_idle", bus.idle_o, 1);
    chk("rst_issue_ready", bus.issue_ready_o, 1);
    chk("rst_clk_en", bus.mul_clk_en_o, 1);
    tick();

    run_one("mul_9x10", MUL_U, 32'd9, 32'd10, 5'd3, 32'd90);
    run_one("mulh_big", MULH_U, 32'd91234, 32'd102345, 5'd7, 32'h0000_0002);
    run_one("mulhu_neg", MULHU_U, 32'd9, -32'sd10, 5'd8, 32'h0000_0008);
    run_one("mulh_neg", MULH_U, 32'd9, -32'sd10, 5'd9, 32'hFFFF_FFFF);
    run_one("mulhsu_neg", MULHSU_U, -32'sd2, 32'd3, 5'd10, 32'hFFFF_FFFF);

    // Back-to-back issue, output held for three cycles once tag 1 arrives.
    for (int t = 1; t <= 4; t++) begin
      drive(MUL_U, 32'(t * 3), 32'(t + 100), TW'(t));
      if (t == 4) bus.wb_ready_i = 1'b0;
      tick();
    end
    bus.issue_valid_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_wb_valid", bus.wb_valid_o, 1);
      chk("stall_tag", bus.wb_tag_o, 1);
      chk("stall_clk_en", bus.mul_clk_en_o, 0);
      chk("stall_issue_ready", bus.issue_ready_o, 0);
      tick();
    end
    bus.wb_ready_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk("drain_valid", bus.wb_valid_o, 1);
      chk("drain_tag", bus.wb_tag_o, t);
      chk("drain_result", bus.wb_result_o, exp_stall[t-1]);
      tick();
    end
    @(negedge clk);
    chk("drain_idle", bus.idle_o, 1);
    tick();

    // Flush with the oldest op held at the output and a new issue pending.
    for (int t = 0; t < 3; t++) begin
      drive(MUL_U, 32'(t + 2), 32'd5, TW'(10 + t));
      tick();
    end
    bus.issue_valid_i = 1'b0;
    tick();
    bus.wb_ready_i = 1'b0;
    bus.flush_i    = 1'b1;
    drive(MUL_U, 32'd7, 32'd7, 5'd13);
    @(negedge clk);
    chk("flush_wb_valid", bus.wb_valid_o, 0);
    chk("flush_issue_ready", bus.issue_ready_o, 0);
    chk("flush_clk_en", bus.mul_clk_en_o, 1);
    tick();
    bus.flush_i       = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.wb_ready_i    = 1'b1;
    @(negedge clk);
    chk("flush_inflight", bus.inflight_o, 0);
    chk("flush_idle", bus.idle_o, 1);
    seen = 0;
    for (int s = 0; s < 8; s++) begin
      tick();
      @(negedge clk);
      if (bus.wb_valid_o) seen++;
    end
    chk("flush_no_wb", seen, 0);
    tick();

    // Reset with two ops in flight and the output stalled.
    bus.wb_ready_i = 1'b0;
    drive(MUL_U, 32'd4, 32'd4, 5'd20);
    tick();
    drive(MUL_U, 32'd5, 32'd5, 5'd21);
    tick();
    bus.issue_valid_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_wb_valid", bus.wb_valid_o, 1);
    chk("pre_rst_clk_en", bus.mul_clk_en_o, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wb_valid", bus.wb_valid_o, 0);
    chk("post_rst_inflight", bus.inflight_o, 0);
    chk("post_rst_clk_en", bus.mul_clk_en_o, 1);
    chk("post_rst_issue_ready", bus.issue_ready_o, 1);
    tick();
    bus.wb_ready_i = 1'b1;
    run_one("post_rst_45", MUL_U, 32'd45, 32'd1, 5'd2, 32'd45);

    // Random issue and back-pressure; ordering and products come from the scoreboard.
    base_acc = n_acc;
    base_ret = n_ret;
    cyc      = 0;
    while ((n_acc - base_acc) < 1000 && cyc < 20000) begin
      drive(mul_ops_e'(2'($urandom_range(0, 3))), $urandom, $urandom, TW'(n_acc));
      bus.issue_valid_i = ($urandom_range(0, 3) != 0);
      bus.wb_ready_i    = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("rand_issued", (n_acc - base_acc) >= 1000, 1);
    bus.issue_valid_i = 1'b0;
    bus.wb_ready_i    = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.idle_o && cyc < 20) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    chk("rand_drained", bus.idle_o, 1);
    chk("rand_retired", n_ret - base_ret, n_acc - base_acc);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mgt_01_mul_sched.md
Name: mgt_01_mul_sched

Overview:
- Issue/retire controller for the pipelined multiplier MGT_01_mul_IP. It accepts multiply requests over a valid/ready handshake and drives the multiplier's operands, operation and clock enable.
- Tracks every in-flight operation (valid bit plus destination tag) in lockstep with the multiplier pipeline and presents results to writeback with back-pressure.
- Sits between the execute-stage issue logic and the writeback arbiter.

Parameters:
- MUL_LATENCY, 4: number of clk_en-gated register stages in MGT_01_mul_IP, including its operand-capture register.
- TAG_W, 5: width of the destination tag (register index).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: synchronous, active-high
- issue_valid_i  in  1  request valid
- issue_ready_o  out  1  request accepted this cycle when high together with issue_valid_i
- issue_ops_i  in  mul_ops_e  operation (MUL_U, MULH_U, MULHSU_U, MULHU_U)
- issue_op_A_i  in  data_u  multiplicand
- issue_op_B_i  in  data_u  multiplier
- issue_tag_i  in  TAG_W  destination tag
- flush_i  in  1  kill all in-flight and presented operations
- mul_op_A_o  out  data_u  to MGT_01_mul_IP op_A_i
- mul_op_B_o  out  data_u  to MGT_01_mul_IP op_B_i
- mul_ops_o  out  mul_ops_e  to MGT_01_mul_IP ops_i
- mul_clk_en_o  out  1  to MGT_01_mul_IP clk_en_i
- mul_result_i  in  data_u  from MGT_01_mul_IP result_o
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  writeback accepts the result
- wb_result_o  out  data_u  result
- wb_tag_o  out  TAG_W  result tag
- inflight_o  out  $clog2(MUL_LATENCY+1)  count of live operations
- idle_o  out  1  no live operations

Behaviour:
- State:
  - vld_q[0..L-1] and tag_q[0..L-1] shift registers, L = MUL_LATENCY.
  - Index L-1 is the output stage, aligned with mul_result_i.
- Reset:
  - All vld_q and tag_q cleared.
  - Outputs: wb_valid_o=0, inflight_o=0, idle_o=1, issue_ready_o=1, mul_clk_en_o=1.
  - Reset dominates flush_i and issue.
- Advance and enables:
  - advance = !(vld_q[L-1] && !wb_ready_i) || flush_i.
  - mul_clk_en_o = advance, combinational.
  - When advance=0, both pipelines freeze together; no loss and no duplication.
- Issue:
  - issue_ready_o = advance && !flush_i.
  - mul_op_A_o, mul_op_B_o and mul_ops_o are a combinational pass-through of the issue inputs.
  - On each advancing edge: vld_q[0] <= issue_valid_i && issue_ready_o; tag_q[0] <= issue_tag_i; stages i>0 take i-1.
  - Non-issue cycles insert bubbles (vld=0). The multiplier result for a bubble is ignored.
- Latency and throughput:
  - An operation accepted at edge n has wb_valid_o=1 after edge n+L-1, assuming no stalls. Each stall cycle adds one cycle.
  - Throughput is 1 operation/cycle; results retire in issue order.
- Output:
  - wb_valid_o = vld_q[L-1] && !flush_i.
  - wb_result_o = mul_result_i.
  - wb_tag_o = tag_q[L-1].
  - A result is retired on the edge where wb_valid_o && wb_ready_i.
- Flush:
  - Every vld_q clears on the next edge. No issue is accepted in the flush cycle.
  - flush_i has priority over issue and over stall.
  - Tags are don't-care after flush.
- Status:
  - inflight_o = popcount(vld_q).
  - idle_o = (inflight_o==0).
- Boundaries:
  - When L-1 is full and wb_ready_i=0 while the pipeline is full, nothing moves and issue is blocked.
  - Issue and retire in the same cycle are both honoured.
  - The same tag may be in flight twice; it is not checked.

Decomposition:
- mgt_01_pkg: mul_ops_e, data_u, MUL_LATENCY_DEF=4, TAG_W_DEF=5.
- Sub-module mgt_01_mul_track: a generic parameterized valid/tag shift register with enable and flush, reused for the divider scheduler later.
- The top level instantiates mgt_01_mul_track only. The multiplier is instantiated outside, by the execute unit.

Test Plan:
- MUL_U, A=9, B=10, tag=3, wb_ready=1 → wb_valid_o=1 after 3 more edges with result 90 and tag 3; inflight_o goes 1→0 after retire.
- MULH_U, A=91234, B=102345, tag=7 → result 0x00000002. MULHU_U, A=9, B=-10 → 0x00000008. MULH_U, A=9, B=-10 → 0xFFFFFFFF.
- 4 back-to-back issues with tags 1..4, and wb_ready_i=0 for 3 cycles when tag 1 reaches output:
  - During the stall: mul_clk_en_o=0, issue_ready_o=0, and wb_tag_o stays 1.
  - After release: tags 1,2,3,4 retire on consecutive cycles with correct products.
- 3 operations in flight, flush_i pulsed while issue_valid_i=1 → wb_valid_o=0 that cycle, issue not accepted, inflight_o=0 and idle_o=1 next cycle, no later wb_valid_o.
- rst_i asserted with 2 operations in flight and the output stalled → next cycle wb_valid_o=0, inflight_o=0, mul_clk_en_o=1, issue_ready_o=1; a new MUL_U 45×1 then returns 45.
- Random issue and wb_ready pattern, 1000 ops, scoreboard → every tag retires exactly once, in order, with the product matching a reference model for all four ops.
